// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter:
// FSM state encoding, parity-mode constants and the bit-timer helper.
package uart_pkg;

  // S_BREAK is only reachable when UART_TX_BREAK_EN is defined.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Last value of the bit timer: round(clk_freq / baud) - 1.
  function automatic int bit_tmr_max(input longint clk_freq, input longint baud);
    return int'((clk_freq + baud / 2) / baud - 1);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the UART transmitter.
// A push is ignored when full (even if a pop happens in the same cycle);
// a pop is ignored when empty. full_o is registered.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             full_q, full_d;
  logic             do_push, do_pop;

  // Qualify requests and compute next pointers, occupancy and full flag.
  always_comb begin
    do_push  = push_i && !full_q;
    do_pop   = pop_i && (level_q != '0);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(do_push) - LW'(do_pop);
    full_d   = (level_d == LW'(DEPTH));
  end

  // Pointer, occupancy and full-flag registers; reset flushes the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with input FIFO.
// Frame: start, DATA_BITS data (LSB first), optional parity, STOP_BITS stops.
// Optional feature macro UART_TX_BREAK_EN adds the BREAK input, which holds
// the line low between frames while it is asserted.
//
// Write handshake: a byte is accepted on a rising CLK edge where SEND and
// READY are both high; SEND while READY is low drops the byte and raises
// OVERRUN for exactly one cycle.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        SEND,
  input  logic [DATA_BITS-1:0]        DATA,
`ifdef UART_TX_BREAK_EN
  input  logic                        BREAK,
`endif
  output logic                        READY,
  output logic                        BUSY,
  output logic                        OVERRUN,
  output logic [$clog2(FIFO_DEPTH):0] LEVEL,
  output logic                        TX
);

  localparam int BIT_TMR_MAX = bit_tmr_max(CLK_FREQ, BAUD);
  localparam int TW = (BIT_TMR_MAX > 0) ? $clog2(BIT_TMR_MAX + 1) : 1;
  localparam int BW = 4;

  tx_state_e            state_q, state_d;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 overrun_q, overrun_d;

  logic                 bit_end;
  logic                 pop;
  logic                 push;
  logic                 brk;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;

`ifdef UART_TX_BREAK_EN
  assign brk = BREAK;
`else
  assign brk = 1'b0;
`endif

  assign push = SEND && !fifo_full;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (push),
    .wdata_i (DATA),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (LEVEL)
  );

  // Next-state, bit timer, shifter and the line value for the next cycle.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    par_d     = par_q;
    pop       = 1'b0;
    overrun_d = SEND && fifo_full;
    bit_end   = (tmr_q == TW'(BIT_TMR_MAX));

    // Timer runs only inside a frame; every transition happens on bit_end,
    // so the wrap to 0 doubles as the restart on state entry.
    if (state_q != S_IDLE && state_q != S_BREAK) begin
      tmr_d = bit_end ? '0 : tmr_q + TW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (brk) begin
          state_d = S_BREAK;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
            sh_d  = sh_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == BW'(STOP_BITS - 1)) begin
            bit_d = '0;
            if (brk) begin
              state_d = S_BREAK;
            end else if (!fifo_empty) begin
              // Back-to-back: next start bit follows the last stop bit directly.
              pop     = 1'b1;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_BREAK: begin
        if (!brk) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (pop) begin
      sh_d  = fifo_rdata;
      par_d = (PARITY == PAR_ODD) ? ~^fifo_rdata : ^fifo_rdata;
    end

    // TX is registered, so it is derived from where the FSM is going.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = sh_d[0];
      S_PARITY: tx_d = par_d;
      S_BREAK:  tx_d = 1'b0;
      default:  tx_d = 1'b1;
    endcase
  end

  // FSM, timer, shifter and output registers; reset aborts any frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      overrun_q <= overrun_d;
    end
  end

  assign TX      = tx_q;
  assign READY   = !fifo_full;
  assign OVERRUN = overrun_q;
  assign BUSY    = ((state_q != S_IDLE) && (state_q != S_BREAK)) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: three instances (8N1, 7E2, 8O1) at 16 cycles/bit
// share one stimulus stream and are each compared every cycle against a
// frame-level model (byte queue plus position within the current frame).
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst;
  logic       send;
  logic       brk;
  logic [7:0] data;

  logic [2:0]      tx_w, rdy_w, busy_w, ovr_w;
  logic [2:0][2:0] lvl_w;

  int  n_chk  = 0;
  int  n_fail = 0;
  bit  chk_en = 1'b0;

  // Model state per instance
  logic [7:0] mq [3][4];
  int         mcnt  [3];
  bit         m_act [3];
  int         m_age [3];
  logic [7:0] m_cur [3];
  bit         m_brk [3];
  bit         m_ovr [3];

  always #5 clk = ~clk;

  uart_tx_cfg #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .CLK(clk), .RST(rst), .SEND(send), .DATA(data[7:0]),
`ifdef UART_TX_BREAK_EN
    .BREAK(brk),
`endif
    .READY(rdy_w[0]), .BUSY(busy_w[0]), .OVERRUN(ovr_w[0]), .LEVEL(lvl_w[0]), .TX(tx_w[0]));

  uart_tx_cfg #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut1 (
    .CLK(clk), .RST(rst), .SEND(send), .DATA(data[6:0]),
`ifdef UART_TX_BREAK_EN
    .BREAK(brk),
`endif
    .READY(rdy_w[1]), .BUSY(busy_w[1]), .OVERRUN(ovr_w[1]), .LEVEL(lvl_w[1]), .TX(tx_w[1]));

  uart_tx_cfg #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut2 (
    .CLK(clk), .RST(rst), .SEND(send), .DATA(data[7:0]),
`ifdef UART_TX_BREAK_EN
    .BREAK(brk),
`endif
    .READY(rdy_w[2]), .BUSY(busy_w[2]), .OVERRUN(ovr_w[2]), .LEVEL(lvl_w[2]), .TX(tx_w[2]));

  function automatic int cfg_nb(input int d);
    return (d == 1) ? 7 : 8;
  endfunction

  function automatic int cfg_par(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 1);
  endfunction

  function automatic int cfg_ns(input int d);
    return (d == 1) ? 2 : 1;
  endfunction

  function automatic int flen(input int d);
    return 16 * (1 + cfg_nb(d) + ((cfg_par(d) != 0) ? 1 : 0) + cfg_ns(d));
  endfunction

  function automatic logic [7:0] mask(input int d, input logic [7:0] v);
    return (d == 1) ? {1'b0, v[6:0]} : v;
  endfunction

  // Line level for bit time k of a frame carrying v.
  function automatic logic frame_bit(input int d, input logic [7:0] v, input int k);
    int nb;
    nb = cfg_nb(d);
    if (k == 0) return 1'b0;
    if (k <= nb) return v[k-1];
    if (cfg_par(d) != 0 && k == nb + 1) return (cfg_par(d) == 1) ? ~^v : ^v;
    return 1'b1;
  endfunction

  function automatic logic [6:0] exp_obs(input int d);
    logic tx;
    if (m_act[d]) tx = frame_bit(d, m_cur[d], m_age[d] / 16);
    else          tx = m_brk[d] ? 1'b0 : 1'b1;
    return {tx, (mcnt[d] < 4), (m_act[d] || mcnt[d] != 0), m_ovr[d], 3'(mcnt[d])};
  endfunction

  function automatic logic [6:0] obs(input int d);
    return {tx_w[d], rdy_w[d], busy_w[d], ovr_w[d], lvl_w[d]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One rising edge of the reference model, using the inputs seen at that edge.
  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      int pre;
      bit take;
      pre  = mcnt[d];
      take = 1'b0;
      if (rst) begin
        mcnt[d]  = 0;
        m_act[d] = 1'b0;
        m_age[d] = 0;
        m_brk[d] = 1'b0;
        m_ovr[d] = 1'b0;
      end else begin
        if (m_act[d]) begin
          m_age[d]++;
          if (m_age[d] == flen(d)) begin
            m_act[d] = 1'b0;
            take     = 1'b1;
          end
        end else if (!m_brk[d]) begin
          take = 1'b1;
        end else if (!brk) begin
          m_brk[d] = 1'b0;
        end
        if (take) begin
          if (brk) begin
            m_brk[d] = 1'b1;
          end else if (pre > 0) begin
            m_cur[d] = mq[d][0];
            for (int i = 0; i < 3; i++) mq[d][i] = mq[d][i+1];
            mcnt[d]--;
            m_act[d] = 1'b1;
            m_age[d] = 0;
          end
        end
        m_ovr[d] = send && (pre == 4);
        if (send && pre < 4) begin
          mq[d][mcnt[d]] = mask(d, data);
          mcnt[d]++;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Compare every instance against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int d = 0; d < 3; d++) check($sformatf("dut%0d outputs", d), 32'(obs(d)), 32'(exp_obs(d)));
      end
    end
  end

  // Push one byte into idle instances and capture TX at mid-bit for 11 bit times.
  task automatic run_frame(input logic [7:0] v, output logic [10:0] c0, output logic [10:0] c1,
                           output logic [10:0] c2);
    @(negedge clk); send = 1'b1; data = v;
    @(negedge clk); send = 1'b0;
    @(negedge clk);
    repeat (8) @(negedge clk);
    for (int k = 0; k < 11; k++) begin
      if (k > 0) repeat (16) @(negedge clk);
      c0[k] = tx_w[0];
      c1[k] = tx_w[1];
      c2[k] = tx_w[2];
    end
    check("8N1 busy after 160-cycle frame", 32'(busy_w[0]), 32'd0);
    check("7E2 busy inside 176-cycle frame", 32'(busy_w[1]), 32'd1);
    repeat (16) @(negedge clk);
  endtask

  initial begin
    logic [10:0] c0, c1, c2;
    rst = 1'b1; send = 1'b0; brk = 1'b0; data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    for (int d = 0; d < 3; d++) begin
      check("reset tx", 32'(tx_w[d]), 32'd1);
      check("reset ready", 32'(rdy_w[d]), 32'd1);
      check("reset busy", 32'(busy_w[d]), 32'd0);
      check("reset level", 32'(lvl_w[d]), 32'd0);
    end

    // 0x55 on all three lines
    run_frame(8'h55, c0, c1, c2);
    check("8N1 0x55 bits", 32'(c0), 32'b11010101010);
    check("7E2 0x55 bits", 32'(c1), 32'b11010101010);
    check("8O1 0x55 bits", 32'(c2), 32'b11010101010);

    // 0xC1: 7E2 sees 0x41
    run_frame(8'hC1, c0, c1, c2);
    check("8N1 0xC1 bits", 32'(c0), 32'b11110000010);
    check("7E2 0x41 bits", 32'(c1), 32'b11010000010);
    check("8O1 0xC1 bits", 32'(c2), 32'b10110000010);

    // Odd parity boundaries
    run_frame(8'hFF, c0, c1, c2);
    check("8O1 0xFF bits", 32'(c2), 32'b11111111110);
    run_frame(8'h01, c0, c1, c2);
    check("8O1 0x01 bits", 32'(c2), 32'b10000000010);

    // Six consecutive writes into a depth-4 FIFO
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); send = 1'b1; data = 8'hA0 + 8'(i);
    end
    @(negedge clk); send = 1'b0;
    check("burst overrun pulse", 32'(ovr_w[0]), 32'd1);
    check("burst ready low", 32'(rdy_w[0]), 32'd0);
    check("burst level full", 32'(lvl_w[0]), 32'd4);
    @(negedge clk);
    check("burst overrun one cycle", 32'(ovr_w[0]), 32'd0);
    repeat (950) @(negedge clk);
    check("burst drained level", 32'(lvl_w[1]), 32'd0);
    check("burst drained busy", 32'(busy_w[1]), 32'd0);

    // Reset during data bit 3 with two bytes queued
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); send = 1'b1; data = 8'h30 + 8'(i);
    end
    @(negedge clk); send = 1'b0;
    repeat (69) @(negedge clk);
    check("level before reset", 32'(lvl_w[0]), 32'd2);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("mid-frame reset tx", 32'(tx_w[0]), 32'd1);
    check("mid-frame reset level", 32'(lvl_w[0]), 32'd0);
    check("mid-frame reset ready", 32'(rdy_w[0]), 32'd1);
    check("mid-frame reset busy", 32'(busy_w[0]), 32'd0);
    repeat (300) @(negedge clk);
    check("post-reset line idle", 32'(tx_w[0]), 32'd1);

`ifdef UART_TX_BREAK_EN
    // Break raised mid-frame with a second byte queued behind it
    @(negedge clk); send = 1'b1; data = 8'h3C;
    @(negedge clk); send = 1'b0;
    repeat (40) @(negedge clk);
    brk = 1'b1; send = 1'b1; data = 8'h5A;
    @(negedge clk); send = 1'b0;
    repeat (300) @(negedge clk);
    check("break holds line low", 32'(tx_w[0]), 32'd0);
    check("break keeps queued byte", 32'(lvl_w[0]), 32'd1);
    brk = 1'b0;
    repeat (400) @(negedge clk);
    check("after break drained", 32'(lvl_w[0]), 32'd0);
`endif

    // Randomized traffic at varying write rates
    for (int blk = 0; blk < 12; blk++) begin
      int rate;
      rate = $urandom_range(0, 3);
      for (int c = 0; c < 500; c++) begin
        @(negedge clk);
        case (rate)
          0:       send = ($urandom_range(0, 399) == 0);
          1:       send = ($urandom_range(0, 99) == 0);
          2:       send = ($urandom_range(0, 19) == 0);
          default: send = ($urandom_range(0, 1) == 1);
        endcase
        data = 8'($urandom);
        rst  = ($urandom_range(0, 2999) == 0);
`ifdef UART_TX_BREAK_EN
        if ($urandom_range(0, 599) == 0) brk = ~brk;
`endif
      end
    end
    @(negedge clk); send = 1'b0; rst = 1'b0; brk = 1'b0;
    repeat (1200) @(negedge clk);
    check("final level", 32'(lvl_w[0]), 32'd0);
    check("final busy", 32'(busy_w[2]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
